// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: reverse-Polish token evaluator in front of a LIFO stack.
// It is the only master of the stack strobes. It keeps its own occupancy count
// so that it can reject tokens that would overflow or underflow the stack.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a token; tok_ready=1; acceptance checks run here
// POP1  | stk_pop=1; removes the top entry (binary op or OUT)
// POP2  | stk_pop=1; removes the second entry; B <- former top at exit
// EXEC  | stk_rdata is A (former second entry); A op B -> stk_wdata
// PUSHR | stk_push=1; writes stk_wdata (immediate or ALU result)
// OUTC  | res_valid=1; res_data shows the value popped in POP1
module rpn_stack_engine #(
  parameter int DEPTH = 100,
  parameter int DW    = 32,
  parameter int CW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic [2:0]    tok_op,
  input  logic [DW-1:0] tok_data,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_wdata,
  input  logic [DW-1:0] stk_rdata,
  input  logic          stk_full,
  input  logic          stk_empty,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          err,
  output logic [CW-1:0] occupancy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP1  = 3'd1,
    S_POP2  = 3'd2,
    S_EXEC  = 3'd3,
    S_PUSHR = 3'd4,
    S_OUTC  = 3'd5
  } state_t;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_OUT  = 3'b110;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  state_t        state_q, state_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [2:0]    op_q, op_d;
  logic          err_q, err_d;
  logic [DW-1:0] alu_res;

  // ALU: A is the entry arriving on stk_rdata in EXEC, B the captured former top.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = stk_rdata + b_q;
      OP_SUB:  alu_res = stk_rdata - b_q;
      OP_AND:  alu_res = stk_rdata & b_q;
      OP_OR:   alu_res = stk_rdata | b_q;
      OP_XOR:  alu_res = stk_rdata ^ b_q;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic: acceptance checks in IDLE, sequencing through pops/push.
  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    wdata_d    = wdata_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    op_d       = op_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tok_valid) begin
          case (tok_op)
            OP_PUSH: begin
              if ((occ_q < DEPTH_C) && !stk_full) begin
                wdata_d = tok_data;
                state_d = S_PUSHR;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              if (occ_q >= TWO_C) begin
                op_d    = tok_op;
                state_d = S_POP1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_OUT: begin
              if ((occ_q >= ONE_C) && !stk_empty) begin
                op_d    = tok_op;
                state_d = S_POP1;
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_POP1: begin
        occ_d   = occ_q - ONE_C;
        state_d = (op_q == OP_OUT) ? S_OUTC : S_POP2;
      end
      S_POP2: begin
        // stk_rdata still shows the POP1 value (the former top) before this edge.
        occ_d   = occ_q - ONE_C;
        b_d     = stk_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        wdata_d = alu_res;
        state_d = S_PUSHR;
      end
      S_PUSHR: begin
        occ_d   = occ_q + ONE_C;
        state_d = S_IDLE;
      end
      S_OUTC: begin
        res_data_d = stk_rdata;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared by the reset shared with the stack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      occ_q      <= '0;
      wdata_q    <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      op_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      wdata_q    <= wdata_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      op_q       <= op_d;
      err_q      <= err_d;
    end
  end

  // Moore outputs; res_data bypasses the holding register during OUTC.
  always_comb begin
    tok_ready = (state_q == S_IDLE);
    stk_push  = (state_q == S_PUSHR);
    stk_pop   = (state_q == S_POP1) || (state_q == S_POP2);
    stk_wdata = wdata_q;
    res_valid = (state_q == S_OUTC);
    res_data  = (state_q == S_OUTC) ? stk_rdata : res_data_q;
    err       = err_q;
    occupancy = occ_q;
  end

endmodule

// File: doc/rpn_stack_engine.md
Name: rpn_stack_engine

Overview:
- Token-driven reverse-Polish evaluator that sits directly in front of the 32-bit, 100-entry LIFO stack.
- It is the only master of the stack's push/pop/write_data.
- It consumes the stack's registered read_data, stack_full and stack_empty.
- It accepts opcode/operand tokens over a valid/ready handshake and emits popped results on a one-cycle output strobe.

Parameters:
DEPTH, 100, stack capacity in entries; must equal the attached stack's depth.
DW, 32, data width of operands, stack entries and results.
CW, 7, width of the occupancy counter; 2**CW > DEPTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset, shared with the stack.
tok_valid  input  1  token present.
tok_ready  output  1  engine can accept a token this cycle.
tok_op  input  3  opcode: 000 PUSH, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 OUT, 111 reserved.
tok_data  input  DW  immediate operand; used by PUSH only.
stk_push  output  1  stack push strobe.
stk_pop  output  1  stack pop strobe.
stk_wdata  output  DW  stack write_data.
stk_rdata  input  DW  stack read_data; updated at the clock edge that ends a pop cycle.
stk_full  input  1  stack full flag.
stk_empty  input  1  stack empty flag.
res_valid  output  1  one-cycle strobe; res_data holds the popped value.
res_data  output  DW  result of the last OUT.
err  output  1  one-cycle strobe; the token was rejected.
occupancy  output  CW  engine's count of stack entries.

Behaviour:
- Reset (asynchronous, rst=1):
  - State IDLE, occupancy=0.
  - stk_push=0, stk_pop=0, stk_wdata=0, res_valid=0, res_data=0, err=0, internal B register=0.
  - Reset mid-operation abandons the token. The stack resets on the same rst, so both sides agree on empty.
- Handshake:
  - tok_ready=1 only in IDLE.
  - A token is accepted on any edge where tok_valid && tok_ready.
  - No pipelining: one token in flight at a time.
- Stack strobes:
  - stk_push and stk_pop are Moore outputs of the FSM.
  - They are never both 1 in the same cycle.
  - Each is high for exactly one cycle per stack operation.
- Acceptance checks, in IDLE; a failing check gives err=1 next cycle, the stack is untouched and the state stays IDLE:
  - PUSH requires occupancy<DEPTH && !stk_full.
  - ADD, SUB, AND, OR and XOR require occupancy>=2.
  - OUT requires occupancy>=1 && !stk_empty.
  - Opcode 111 always errors.
- FSM states: IDLE, POP1, POP2, EXEC, PUSHR, OUTC.
  - PUSH: IDLE -> PUSHR. In PUSHR, stk_push=1 and stk_wdata=latched tok_data; occupancy+1. Then IDLE. Push issues 1 cycle after acceptance.
  - Binary ops: IDLE -> POP1 (stk_pop=1) -> POP2 (stk_pop=1).
    - At the end-of-POP2 edge, B is captured from stk_rdata; B is the former top.
    - EXEC: A=stk_rdata, the former second entry. Result = A op B, registered into stk_wdata.
    - PUSHR (stk_push=1) -> IDLE.
    - Net occupancy change is -1. The token occupies 4 cycles after acceptance; tok_ready returns in the 5th.
  - SUB computes A-B, modulo 2**DW, with no overflow flag. ADD wraps modulo 2**DW. AND, OR and XOR are bitwise.
  - OUT: IDLE -> POP1 (stk_pop=1; occupancy-1) -> OUTC. In OUTC, res_data=stk_rdata and res_valid=1 for that cycle. Then IDLE.
- occupancy:
  - Increments in PUSHR and decrements in each POP cycle.
  - Never exceeds DEPTH and never underflows, guaranteed by the acceptance checks.
- Simultaneous events: tok_valid while busy is ignored; the token must be held until tok_ready.
- err and res_valid never assert in the same cycle.

Test Plan:
1. Reset, then PUSH 5, PUSH 3, SUB, OUT -> stk_wdata=2 pushed; res_valid pulse with res_data=2; occupancy ends 0; no err.
2. PUSH 0xFFFFFFFF, PUSH 1, ADD, OUT -> res_data=0 (wrap). Strobe timing: pops on acceptance+1 and +2, push on +4.
3. On empty stack: ADD -> err pulse, no stk_pop. OUT -> err pulse. PUSH 7, then ADD -> err; occupancy stays 1.
4. 100 PUSHes of 0..99 -> occupancy=100, stk_full=1. 101st PUSH -> err, no stk_push. Then XOR -> pushes 98^99=1; occupancy=99.
5. PUSH 0xF0F0, PUSH 0x0FF0, AND, OUT -> 0x00F0. Repeat with OR -> 0xFFF0.
6. Assert rst during EXEC of an ADD -> outputs return to reset values immediately; tok_ready=1 after release. OUT -> err (occupancy 0).
